// File: rtl/seg_wb_pkg.sv
// rtl/seg_wb_pkg.sv - shared types and default sizes for the Wishbone single-transfer initiator
package seg_wb_pkg;

  localparam int ADDR_W_DEF         = 32;
  localparam int DATA_W_DEF         = 32;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } wb_state_e;

  typedef enum logic {
    STS_OK  = 1'b0,
    STS_ERR = 1'b1
  } rsp_status_e;

endpackage

// File: rtl/seg_wb_timeout.sv
// rtl/seg_wb_timeout.sv - strobe-length watchdog for the initiator
// expired is high during the TIMEOUT_CYCLES-th consecutive enabled cycle after a clear.
module seg_wb_timeout
  import seg_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/seg_wb_initiator.sv
// rtl/seg_wb_initiator.sv - Wishbone classic single-transfer initiator with valid/ready command port
// Optional strobe timeout is built when SEG_WB_TIMEOUT_EN is defined.
module seg_wb_initiator
  import seg_wb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                I_req_valid,
  output logic                O_req_ready,
  input  logic                I_req_we,
  input  logic [ADDR_W-1:0]   I_req_adr,
  input  logic [DATA_W-1:0]   I_req_dat,
  input  logic [DATA_W/8-1:0] I_req_sel,
  output logic                O_rsp_valid,
  output logic [DATA_W-1:0]   O_rsp_dat,
  output logic                O_rsp_err,
  output logic [ADDR_W-1:0]   ADR_O,
  output logic [DATA_W-1:0]   DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  output logic                WE_O,
  output logic                CYC_O,
  output logic                STB_O,
  input  logic [DATA_W-1:0]   DAT_I,
  input  logic                ACK_I,
  input  logic                ERR_I
);

  if (DATA_W % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("seg_wb_initiator: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES at least 1");
  end

  wb_state_e   state_q, state_d;
  rsp_status_e status;
  logic        rsp_fire;
  logic        timeout_hit;

`ifdef SEG_WB_TIMEOUT_EN
  seg_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK_I),
    .rst    (RST_I),
    .clear  (state_q == IDLE),
    .enable (state_q == BUS),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Termination priority: ERR_I over ACK_I, and a real termination over the timeout.
  always_comb begin
    state_d  = state_q;
    rsp_fire = 1'b0;
    status   = STS_OK;
    case (state_q)
      IDLE: if (I_req_valid) state_d = BUS;
      BUS: begin
        if (ERR_I) begin
          rsp_fire = 1'b1;
          status   = STS_ERR;
        end else if (ACK_I) begin
          rsp_fire = 1'b1;
        end else if (timeout_hit) begin
          rsp_fire = 1'b1;
          status   = STS_ERR;
        end
        if (rsp_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      ADR_O       <= '0;
      DAT_O       <= '0;
      SEL_O       <= '0;
      WE_O        <= 1'b0;
      O_rsp_valid <= 1'b0;
      O_rsp_dat   <= '0;
      O_rsp_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      O_rsp_valid <= rsp_fire;
      if (state_q == IDLE && I_req_valid) begin
        ADR_O <= I_req_adr;
        DAT_O <= I_req_dat;
        SEL_O <= I_req_sel;
        WE_O  <= I_req_we;
      end
      if (rsp_fire) begin
        O_rsp_err <= (status == STS_ERR);
        O_rsp_dat <= (status == STS_OK && !WE_O) ? DAT_I : '0;
      end
    end
  end

  assign O_req_ready = (state_q == IDLE);
  assign CYC_O       = (state_q == BUS);
  assign STB_O       = (state_q == BUS);

endmodule

// File: doc/seg_wb_initiator.md
# seg_wb_initiator

Wishbone classic single-transfer initiator (bus master) that issues the bus cycles consumed by Wishbone responders such as the seven-segment display peripheral. It accepts one request at a time from a simple valid/ready command port, runs one Wishbone read or write, and returns the read data and a completion status on a response port. It sits between a CPU-side or test-side command source and the peripheral bus on the 100 MHz board clock.

## Interface
- ADDR_W, 32: Wishbone address width.
- DATA_W, 32: Wishbone data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255: maximum cycles STB_O is held without termination (only used with timeout enabled); minimum 1.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- RST_I  in  1  synchronous, active-high reset.
- I_req_valid  in  1  command present.
- O_req_ready  out  1  initiator idle; command accepted when valid&ready at a rising edge.
- I_req_we  in  1  1 = write, 0 = read.
- I_req_adr  in  ADDR_W  target address.
- I_req_dat  in  DATA_W  write data.
- I_req_sel  in  DATA_W/8  byte selects.
- O_rsp_valid  out  1  one-cycle completion pulse.
- O_rsp_dat  out  DATA_W  read data; 0 for writes and errors.
- O_rsp_err  out  1  valid with O_rsp_valid; 1 = ERR_I or timeout.
- ADR_O, DAT_O, SEL_O, WE_O, CYC_O, STB_O  out  ADDR_W, DATA_W, DATA_W/8, 1, 1, 1  Wishbone master outputs.
- DAT_I, ACK_I, ERR_I  in  DATA_W, 1, 1  Wishbone master inputs.

## Operation
- States: IDLE, BUS.
- IDLE: O_req_ready=1, CYC_O=STB_O=0. On I_req_valid: latch we/adr/dat/sel into ADR_O/DAT_O/WE_O/SEL_O, go BUS.
- BUS: CYC_O=STB_O=1, outputs stable, O_req_ready=0. On ACK_I or ERR_I: go IDLE, pulse O_rsp_valid.
- ACK_I: O_rsp_err=0; O_rsp_dat=DAT_I if read, 0 if write.
- ERR_I (including ERR_I with ACK_I same cycle): ERR wins; O_rsp_err=1, O_rsp_dat=0.
- ACK_I/ERR_I while IDLE: ignored, no response.
- I_req_valid while BUS: ignored (ready is low); command source holds it.
- ADR_O/DAT_O/SEL_O/WE_O hold last values in IDLE.
- Reset (any state, including mid-cycle): state IDLE, CYC_O=STB_O=0, WE_O=0, ADR_O/DAT_O/SEL_O=0, O_rsp_valid=0, O_rsp_err=0, O_rsp_dat=0, timeout count 0; the aborted transfer produces no response.

## Timing
- Accept at edge N -> CYC_O/STB_O high in cycle N+1 (1-cycle issue latency).
- ACK_I/ERR_I sampled high at edge M -> CYC_O/STB_O low and O_rsp_valid high in cycle M+1, for exactly one cycle.
- O_req_ready high in cycle M+1; next command accepted at edge M+1 earliest, so at least one idle cycle between STB_O strobes.
- Zero-wait responder (ACK in first STB cycle): accept-to-response = 2 cycles.
- O_rsp_dat/O_rsp_err hold until next response.

## Configuration
- SEG_WB_TIMEOUT_EN defined: counter cleared on entering BUS, increments each BUS cycle without termination; when it reaches TIMEOUT_CYCLES the cycle is terminated as an error (STB_O held exactly TIMEOUT_CYCLES cycles, then same exit as ERR_I). ACK_I/ERR_I on the final counted cycle takes precedence over timeout.
- Undefined: no counter; BUS waits indefinitely for ACK_I/ERR_I.

## Structure
- Package seg_wb_pkg: state enum (IDLE, BUS), default ADDR_W/DATA_W/TIMEOUT_CYCLES constants, response status encoding.
- One sub-module seg_wb_timeout (clear, enable, expired output, TIMEOUT_CYCLES parameter), instantiated only under SEG_WB_TIMEOUT_EN.

## Test plan
- Write, responder ACKs in 1st STB cycle: adr=0x0000_0010, dat=0x0000_1234, sel=0xF -> ADR_O/DAT_O/WE_O=1 match, STB_O high 1 cycle, O_rsp_valid 2 cycles after accept, err=0, dat=0.
- Read with 3 wait states, DAT_I=0xDEAD_BEEF -> STB_O high 4 cycles, O_rsp_dat=0xDEADBEEF, err=0; back-to-back next request accepted on the response cycle.
- ACK_I and ERR_I asserted together -> O_rsp_err=1, O_rsp_dat=0, one pulse.
- SEG_WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder silent -> STB_O high exactly 8 cycles, then O_rsp_err=1; ACK on 8th cycle -> err=0.
- RST_I asserted 2 cycles into a waited read -> CYC_O/STB_O low next cycle, no O_rsp_valid ever, O_req_ready=1 after reset release.
- Spurious ACK_I while IDLE -> no O_rsp_valid, outputs unchanged.
